// File: rtl/bram_req_master.sv
// rtl/bram_req_master.sv - single-outstanding BRAM request master: one-word writes and sequential read bursts
// Drives the wrapper en/we/addr/din pins and returns read words over a valid/ready handshake.
module bram_req_master #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  done,
  output logic                  err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  input  logic                  mem_valid
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_REQ   = 3'd2,
    S_WAIT  = 3'd3,
    S_HOLD  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [TW-1:0]         timer_q, timer_d;

  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  timer_expired;

  assign timer_expired = (timer_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      wdata_q    <= '0;
      timer_q    <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      wdata_q    <= wdata_d;
      timer_q    <= timer_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    wdata_d = wdata_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          rem_d   = cmd_len;
          wdata_d = cmd_wdata;
          if (cmd_we)
            state_d = S_WRITE;
          else if (cmd_len == '0)
            state_d = S_DONE;
          else
            state_d = S_REQ;
        end
      end
      S_WRITE: state_d = S_DONE;
      S_REQ: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A response landing on the last timer cycle is still accepted.
        if (mem_valid)
          state_d = S_HOLD;
        else if (timer_expired)
          state_d = S_DONE;
        else
          timer_d = timer_q + 1'b1;
      end
      S_HOLD: begin
        if (rd_ready) begin
          addr_d  = addr_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          state_d = (rem_q == LEN_WIDTH'(1)) ? S_DONE : S_REQ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs are derived from the next state so they line up with it.
  always_comb begin
    mem_en_d   = (state_d == S_WRITE) || (state_d == S_REQ);
    mem_we_d   = (state_d == S_WRITE);
    mem_addr_d = mem_en_d ? addr_d : mem_addr_q;
    mem_din_d  = (state_d == S_WRITE) ? wdata_d : mem_din_q;
    rd_data_d  = rd_data_q;
    if (state_q == S_WAIT && mem_valid)
      rd_data_d = mem_dout;
    rd_valid_d = (state_d == S_HOLD);
    done_d     = (state_d == S_DONE);
    err_d      = (state_q == S_WAIT) && !mem_valid && timer_expired;
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: doc/bram_req_master.md
Name: bram_req_master

Overview:
- Initiator side of the single-port BRAM wrapper interface: accepts one command at a time from upstream logic and drives the wrapper's en/we/addr/din pins.
- Each command is either a single-word write or a sequential read burst.
- For reads, it waits for the wrapper's one-cycle valid pulse and returns each word to upstream over a valid/ready handshake.
- A response timeout protects against a missing valid pulse.

Parameters:
- ADDR_WIDTH, 15, BRAM word-address width.
- DATA_WIDTH, 32, data word width.
- LEN_WIDTH, 8, width of the burst length field.
- TIMEOUT, 15, maximum cycles to wait for mem_valid after a read request; must be ≥ 2.

Ports:
- clk  in  1  Single clock; all logic is on its rising edge.
- rst  in  1  Reset, synchronous and active-high.
- cmd_valid  in  1  Command offered.
- cmd_ready  out  1  Command accepted when cmd_valid and cmd_ready are both high.
- cmd_we  in  1  1 = write, 0 = read burst.
- cmd_addr  in  ADDR_WIDTH  Start address.
- cmd_len  in  LEN_WIDTH  Read word count; ignored for writes.
- cmd_wdata  in  DATA_WIDTH  Write data.
- rd_data  out  DATA_WIDTH  Read word.
- rd_valid  out  1  rd_data is valid.
- rd_ready  in  1  Upstream accepts the read word.
- done  out  1  One-cycle pulse at the end of each command.
- err  out  1  Qualified by done; 1 = command aborted by timeout.
- mem_en  out  1  To wrapper en.
- mem_we  out  1  To wrapper we.
- mem_addr  out  ADDR_WIDTH  To wrapper addr.
- mem_din  out  DATA_WIDTH  To wrapper din.
- mem_dout  in  DATA_WIDTH  From wrapper dout.
- mem_valid  in  1  From wrapper valid pulse.

Behaviour:
- Reset (rst high at a clock edge, from any state):
  - State goes to IDLE.
  - These outputs are 0: rd_valid, done, err, mem_en, mem_we, mem_addr, mem_din, rd_data.
  - The timer and remaining counter clear.
  - Reset mid-burst abandons the burst with no done pulse; any in-flight mem_valid is ignored after reset.
- Outputs are registered, except cmd_ready = (state == IDLE).
- IDLE:
  - On handshake, latch addr, len, wdata and we.
  - we = 1 goes to WRITE.
  - Read with len = 0 goes to DONE (err = 0, no memory access).
  - Otherwise goes to REQ.
- WRITE:
  - mem_en = 1, mem_we = 1, mem_addr = latched addr, mem_din = wdata for exactly one cycle.
  - Then DONE.
- REQ:
  - mem_en = 1, mem_we = 0, mem_addr = cur_addr for exactly one cycle.
  - Timer cleared, then WAIT_RSP.
- WAIT_RSP:
  - mem_en = 0.
  - If mem_valid is high, capture mem_dout into rd_data, set rd_valid = 1 next cycle, go to HOLD.
  - Otherwise the timer increments; when timer == TIMEOUT-1 without mem_valid, go to DONE with err = 1. Words not yet delivered are dropped.
  - If mem_valid and the timeout coincide, mem_valid wins.
- HOLD:
  - rd_valid = 1 and rd_data is stable until rd_ready.
  - On rd_ready, rd_valid drops next cycle, cur_addr increments modulo 2^ADDR_WIDTH (0x7FFF wraps to 0x0000), and remaining decrements.
  - If remaining was 1, go to DONE (err = 0); else go to REQ.
  - Back-pressure may last indefinitely; no timeout applies in HOLD.
- DONE: done = 1 for one cycle with err valid, then IDLE. err returns to 0 the next cycle.
- mem_valid outside WAIT_RSP is ignored.
- No read pipelining: exactly one outstanding read.
- Read beat latency is 1 (REQ) + L (cycles to mem_valid) + 1, plus any rd_ready stall.
- Back-to-back commands: next cmd_ready is the cycle after done.
- Maximum burst is 2^LEN_WIDTH-1 words.

Test Plan:
- Write: cmd_we=1, addr 0x0010, wdata 0xDEADBEEF → exactly one cycle of mem_en=1, mem_we=1, mem_addr=0x0010, mem_din=0xDEADBEEF; done=1, err=0 two cycles after accept.
- Single read, memory model latency 3: addr 0x0005, len 1, model returns 0x12345678 → one mem_en pulse with we=0; rd_valid with 0x12345678 five cycles after REQ; done after rd_ready.
- Burst with stalls: addr 0x0100, len 4, rd_ready low for 3 cycles on beat 2 → reads 0x0100..0x0103 in order; rd_data held during the stall; exactly 4 rd_valid handshakes; one done, err=0.
- Wrap: addr 0x7FFE, len 4 → mem_addr sequence 0x7FFE, 0x7FFF, 0x0000, 0x0001.
- Timeout and zero length: read len 3 with mem_valid never asserted → done=1, err=1 after TIMEOUT cycles in WAIT_RSP, no rd_valid. Read len 0 → done, err=0, no mem_en.
- Reset mid-burst: assert rst for one cycle during HOLD of beat 2 of len 4 → next cycle all outputs 0, cmd_ready=1, no done. A new write then completes normally.
